// File: rtl/gru_weight_streamer_if.sv
// Handshake and RAM-port bundle for the GRU weight streamer.
//   cmd_*   : burst request (base row, row count) with valid/ready
//   ram_*   : single read port of the weight/bias RAM (1-cycle registered read)
//   m_*     : row stream towards the MAC datapath (valid/ready, last marker)
//   busy/done : burst status
// master = command issuer / RAM / stream consumer side, slave = the streamer.
interface gru_weight_streamer_if #(
    parameter int unsigned AWL = 10,
    parameter int unsigned DWL = 144,
    parameter int unsigned LWL = 10
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AWL-1:0] cmd_base;
    logic [LWL-1:0] cmd_len;

    logic           ram_en;
    logic [AWL-1:0] ram_addr;
    logic [DWL-1:0] ram_dout;

    logic           m_valid;
    logic [DWL-1:0] m_data;
    logic           m_last;
    logic           m_ready;

    logic           busy;
    logic           done;

    modport master (
        output cmd_valid, cmd_base, cmd_len, ram_dout, m_ready,
        input  cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, ram_dout, m_ready,
        output cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/gru_weight_streamer.sv
// Read-side sequencer for the GRU weight/bias RAM.
// A command (base, len) produces len consecutive row reads (address wraps modulo 2**AWL);
// returned rows pass through a DEPTH-entry FIFO and leave as a valid/ready stream.
// Ports:
//   clk   : clock, rising edge
//   RSTn  : asynchronous reset, active-low (aborts any burst, no done pulse)
//   bus   : gru_weight_streamer_if.slave (command, RAM port, stream, busy/done)
module gru_weight_streamer #(
    parameter int unsigned AWL   = 10,
    parameter int unsigned DWL   = 144,
    parameter int unsigned LWL   = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  RSTn,
    gru_weight_streamer_if.slave  bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [AWL-1:0] r_addr;
    logic [LWL-1:0] r_issue_left;
    logic [LWL-1:0] r_beat_left;
    logic           r_cmd_ready;
    logic           r_busy;
    logic           r_done;

    logic [DWL-1:0] r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_inflight;

    logic [SW-1:0]  w_outstanding;
    logic           w_ram_en;
    logic           w_m_valid;
    logic           w_pop;
    logic           w_push;
    logic           w_last;

    // Rows already buffered plus the one still in the RAM pipeline must leave room for a new read.
    assign w_outstanding = SW'(r_count) + SW'(r_inflight);
    assign w_ram_en      = (r_state == S_RUN) && (r_issue_left != '0)
                           && (w_outstanding < SW'(DEPTH));
    assign w_m_valid     = (r_count != '0);
    assign w_pop         = w_m_valid & bus.m_ready;
    assign w_push        = r_inflight;
    assign w_last        = w_m_valid && (r_beat_left == LWL'(1));

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ram_en    = w_ram_en;
    assign bus.ram_addr  = r_addr;
    assign bus.m_valid   = w_m_valid;
    assign bus.m_last    = w_last;
    // Head is forced to zero when empty so stale rows never show on the bus.
    assign bus.m_data    = w_m_valid ? r_mem[r_rd_ptr] : '0;

    // Burst control FSM with registered status outputs.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_beat_left  <= '0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_len != '0) begin
                            r_state      <= S_RUN;
                            r_addr       <= bus.cmd_base;
                            r_issue_left <= bus.cmd_len;
                            r_beat_left  <= bus.cmd_len;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_ram_en) begin
                        r_addr       <= r_addr + AWL'(1);
                        r_issue_left <= r_issue_left - LWL'(1);
                    end
                    if (w_pop) begin
                        r_beat_left <= r_beat_left - LWL'(1);
                    end
                    if (w_pop && w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // FIFO control: read-return tracking, pointers and occupancy.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_ram_en;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the count gates the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.ram_dout;
        end
    end
endmodule

// File: tb/tb_gru_weight_streamer.sv
module tb_gru_weight_streamer;
    localparam int unsigned AWL   = 10;
    localparam int unsigned DWL   = 144;
    localparam int unsigned LWL   = 10;
    localparam int unsigned DEPTH = 4;
    localparam int          NROWS = 1 << AWL;
    localparam int          TMO   = 3000;

    typedef struct packed {
        logic [DWL-1:0] data;
        logic           last;
    } beat_t;

    logic clk = 1'b0;
    logic RSTn;
    always #5 clk = ~clk;

    gru_weight_streamer_if #(.AWL(AWL), .DWL(DWL), .LWL(LWL)) bus ();

    gru_weight_streamer #(.AWL(AWL), .DWL(DWL), .LWL(LWL), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus)
    );

    logic [DWL-1:0] ram [NROWS];

    // Behavioural RAM: registered read, data valid the cycle after enable.
    always @(posedge clk) begin
        if (bus.ram_en) bus.ram_dout <= ram[bus.ram_addr];
    end

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    exp_addr_q[$];
    int    issued   = 0;
    int    popped   = 0;
    int    done_cnt = 0;

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    // Monitor: samples mid-cycle, i.e. exactly what the next rising edge will see.
    logic           hold_v;
    logic [DWL-1:0] hold_d;
    logic           exp_done;
    logic           chk_idle;
    initial begin
        hold_v = 0; hold_d = '0; exp_done = 0; chk_idle = 0;
    end

    always @(negedge clk) begin
        if (!RSTn) begin
            hold_v   = 0;
            exp_done = 0;
            chk_idle = 0;
            issued   = 0;
            popped   = 0;
        end else begin
            if (chk_idle) begin
                chk("idle_busy", 160'(bus.busy), 160'(0));
                chk("idle_cmd_ready", 160'(bus.cmd_ready), 160'(1));
                chk_idle = 0;
            end
            if (exp_done || bus.done) begin
                chk("done_pulse", 160'(bus.done), 160'(exp_done));
                if (bus.done) done_cnt++;
                if (exp_done) chk_idle = 1;
                exp_done = 0;
            end
            if (hold_v) begin
                chk("hold_valid", 160'(bus.m_valid), 160'(1));
                chk("hold_data", 160'(bus.m_data), 160'(hold_d));
            end
            if (bus.ram_en) begin
                if (exp_addr_q.size() == 0) chk("spurious_ram_en", 160'(1), 160'(0));
                else chk("ram_addr", 160'(bus.ram_addr), 160'(exp_addr_q.pop_front()));
                chk("rows_ahead_le_depth", 160'((issued - popped) < int'(DEPTH)), 160'(1));
                issued++;
            end
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", 160'(1), 160'(0));
                end else begin
                    chk("m_last", 160'(bus.m_last), 160'(exp_q[0].last));
                    if (bus.m_ready) begin
                        chk("beat_data", 160'(bus.m_data), 160'(exp_q[0].data));
                        if (exp_q[0].last) exp_done = 1;
                        void'(exp_q.pop_front());
                    end
                end
                if (bus.m_ready) popped++;
            end
            if (bus.cmd_valid && bus.cmd_ready && bus.cmd_len == '0) exp_done = 1;
            hold_v = bus.m_valid & ~bus.m_ready;
            hold_d = bus.m_data;
        end
    end

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return !((c >= 5 && c <= 20) || (c > 20 && c % 3 == 0));
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 160'(bus.cmd_ready), 160'(1));
        chk({tag, "_ram_en"},    160'(bus.ram_en),    160'(0));
        chk({tag, "_ram_addr"},  160'(bus.ram_addr),  160'(0));
        chk({tag, "_m_valid"},   160'(bus.m_valid),   160'(0));
        chk({tag, "_m_last"},    160'(bus.m_last),    160'(0));
        chk({tag, "_m_data"},    160'(bus.m_data),    160'(0));
        chk({tag, "_busy"},      160'(bus.busy),      160'(0));
        chk({tag, "_done"},      160'(bus.done),      160'(0));
    endtask

    // Issue one burst; all inputs change 1 time unit after a rising edge.
    task automatic burst(input int base, input int len, input int mode, input int abort_at);
        int c;
        int start_done;
        int start_pop;
        logic aborted;
        aborted = 0;
        chk("cmd_ready_before_cmd", 160'(bus.cmd_ready), 160'(1));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(beat_t'{data: ram[AWL'((base + i) % NROWS)], last: (i == len - 1)});
            exp_addr_q.push_back((base + i) % NROWS);
        end
        start_done    = done_cnt;
        start_pop     = popped;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = AWL'(base);
        bus.cmd_len   = LWL'(len);
        bus.m_ready   = ready_for(mode, 0);
        @(posedge clk); #1;
        chk("busy_after_accept", 160'(bus.busy), 160'(1));
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = AWL'($urandom);
        bus.cmd_len   = LWL'($urandom);
        c = 1;
        while (done_cnt == start_done && c < TMO && !aborted) begin
            if (abort_at > 0 && (popped - start_pop) >= abort_at) begin
                RSTn = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                exp_addr_q.delete();
                repeat (3) @(posedge clk);
                #1;
                chk("abort_no_done", 160'(done_cnt), 160'(start_done));
                check_reset_outputs("abort_hold");
                RSTn    = 1'b1;
                aborted = 1;
            end else begin
                bus.m_ready = ready_for(mode, c);
                @(posedge clk); #1;
                c++;
            end
        end
        if (!aborted) begin
            if (c >= TMO) chk("burst_timeout", 160'(0), 160'(1));
            chk("scoreboard_drained", 160'(exp_q.size()), 160'(0));
            chk("addr_queue_drained", 160'(exp_addr_q.size()), 160'(0));
        end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < NROWS; i++)
            ram[i] = DWL'({$urandom, $urandom, $urandom, $urandom, $urandom});
        RSTn          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b0;

        // Reset held with random inputs.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'($urandom);
            bus.m_ready   = 1'($urandom);
            bus.cmd_base  = AWL'($urandom);
            bus.cmd_len   = LWL'($urandom);
            #2;
            check_reset_outputs("reset");
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.m_ready   = 1'b1;
        RSTn          = 1'b1;
        @(posedge clk); #1;

        burst(0, 195, 0, 0);
        burst(585, 52, 1, 0);
        burst(int'($urandom_range(0, NROWS - 1)), 0, 0, 0);
        burst(1022, 4, 2, 0);
        burst(0, 195, 0, 50);
        burst(10, 3, 0, 0);
        for (int k = 0; k < 6; k++)
            burst(int'($urandom_range(0, NROWS - 1)), int'($urandom_range(1, 40)), 2, 0);
        burst(NROWS - 2, 4, 1, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
